branch_flag_unit: RTL and testbench

Condition-flag register and branch resolver for the pipelined LEGv8 datapath. It captures NZCV from flag-setting ALU operations (ADDS/SUBS/ANDS), performing the 64-bit zero detect internally as four 16-bit NOR groups feeding a 4-input AND. It consumes those flags, or a register operand, to resolve B, CBZ, CBNZ and B.cond one cycle later. It also squashes the single wrong-path branch request that follows a taken branch.

---
 rtl/branch_flag_unit.sv | 133 +++++++++++++
 tb/tb_branch_flag_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_flag_unit.sv
// branch_flag_unit
//
// Condition-flag register and branch resolver for the pipelined LEGv8
// datapath. NZCV is captured from flag-setting ALU ops (ADDS/SUBS/ANDS).
// B, CBZ, CBNZ and B.cond are resolved one cycle after the request. The
// single wrong-path request that follows a taken branch is squashed.
//
// Handshake: there is no backpressure. A request is a single-cycle pulse
// on br_valid. It is accepted when flush=0 and no shadow is active.
// Each accepted request yields exactly one cycle of taken_valid=1 on the
// following cycle, with taken qualified by taken_valid.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   flag_we      in   1      flag-setting ALU op completes this cycle
//   alu_result   in   WIDTH  ALU result used for N and Z
//   alu_c        in   1      ALU carry out
//   alu_v        in   1      ALU signed overflow
//   br_valid     in   1      branch request this cycle
//   br_op        in   2      00 B, 01 CBZ, 10 CBNZ, 11 B.cond
//   br_cond      in   4      condition code for B.cond
//   br_reg       in   WIDTH  register operand for CBZ/CBNZ
//   flush        in   1      kills this cycle's flag_we and br_valid
//   flags        out  4      registered {N,Z,C,V}
//   taken_valid  out  1      registered: resolution result present
//   taken        out  1      registered: branch taken (qualified by taken_valid)
//   shadow_state out  1      debug: 1 while the post-taken shadow is active

module branch_flag_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             br_valid,
  input  logic [1:0]       br_op,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] br_reg,
  input  logic             flush,
  output logic [3:0]       flags,
  output logic             taken_valid,
  output logic             taken,
  output logic             shadow_state
);

  localparam int GROUPS = WIDTH / 16;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } state_t;

  state_t state, state_next;

  // Zero detect built as 16-bit NOR groups feeding a wide AND.
  function automatic logic is_zero(input logic [WIDTH-1:0] val);
    logic [GROUPS-1:0] grp;
    for (int g = 0; g < GROUPS; g++) begin
      grp[g] = ~|val[g*16 +: 16];
    end
    return &grp;
  endfunction

  logic       flag_upd;
  logic [3:0] flags_new;
  logic [3:0] eval_flags;
  logic       accept;
  logic       cond_base;
  logic       taken_next;
  logic       n, z, c, v;

  assign flag_upd  = flag_we & ~flush;
  assign flags_new = {alu_result[WIDTH-1], is_zero(alu_result), alu_c, alu_v};

  // A flag write in the same cycle as a branch belongs to the older
  // instruction, so the branch sees the freshly generated NZCV.
  assign eval_flags   = flag_upd ? flags_new : flags;
  assign {n, z, c, v} = eval_flags;

  assign accept = br_valid & ~flush & (state == IDLE);

  always_comb begin
    cond_base  = 1'b0;
    taken_next = 1'b0;
    // Conditions come in pairs: odd codes invert the even code's test.
    unique case (br_cond[3:1])
      3'd0: cond_base = z;
      3'd1: cond_base = c;
      3'd2: cond_base = n;
      3'd3: cond_base = v;
      3'd4: cond_base = c & ~z;
      3'd5: cond_base = (n == v);
      3'd6: cond_base = ~z & (n == v);
      3'd7: cond_base = 1'b1;
    endcase
    unique case (br_op)
      2'b00: taken_next = 1'b1;
      2'b01: taken_next = is_zero(br_reg);
      2'b10: taken_next = ~is_zero(br_reg);
      2'b11: taken_next = (br_cond[3:1] == 3'd7) ? 1'b1 : (cond_base ^ br_cond[0]);
    endcase
  end

  // Shadow FSM: one squashed slot after every taken branch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (accept && taken_next) state_next = SHADOW;
      SHADOW: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      flags       <= 4'b0000;
      taken_valid <= 1'b0;
      taken       <= 1'b0;
    end else begin
      state       <= state_next;
      taken_valid <= accept;
      taken       <= accept & taken_next;
      if (flag_upd) flags <= flags_new;
    end
  end

  assign shadow_state = (state == SHADOW);

endmodule

// File: tb/tb_branch_flag_unit.sv
module tb_branch_flag_unit;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             flag_we;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;
  logic             br_valid;
  logic [1:0]       br_op;
  logic [3:0]       br_cond;
  logic [WIDTH-1:0] br_reg;
  logic             flush;
  logic [3:0]       flags;
  logic             taken_valid;
  logic             taken;
  logic             shadow_state;

  int passed = 0;
  int total  = 0;

  branch_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flag_we      (flag_we),
    .alu_result   (alu_result),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .br_valid     (br_valid),
    .br_op        (br_op),
    .br_cond      (br_cond),
    .br_reg       (br_reg),
    .flush        (flush),
    .flags        (flags),
    .taken_valid  (taken_valid),
    .taken        (taken),
    .shadow_state (shadow_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flag_we    = 1'b0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    br_valid   = 1'b0;
    br_op      = 2'b00;
    br_cond    = 4'b0000;
    br_reg     = '0;
    flush      = 1'b0;
  endtask

  task automatic set_flags(input logic [WIDTH-1:0] res, input logic c, input logic v);
    flag_we    = 1'b1;
    alu_result = res;
    alu_c      = c;
    alu_v      = v;
    step();
    clear_inputs();
  endtask

  // Issues one request, samples the result, then idles one cycle so any
  // shadow has expired before the next request.
  task automatic do_branch(input logic [1:0] op, input logic [3:0] cond,
                           input logic [WIDTH-1:0] rv,
                           output logic tv, output logic tk);
    br_valid = 1'b1;
    br_op    = op;
    br_cond  = cond;
    br_reg   = rv;
    step();
    clear_inputs();
    tv = taken_valid;
    tk = taken;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    // Highest reachable flag pattern: N, C, V set (N and Z are exclusive).
    set_flags(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    total++; if (flags !== 4'b1011) $display("FAIL reset_preload: flags=%b exp=1011", flags); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (flags !== 4'b0000 || taken_valid !== 1'b0)
      $display("FAIL reset_async: flags=%b tv=%b exp=0000/0", flags, taken_valid); else passed++;
    #1 reset = 1'b1;
    step();
    total++; if (flags !== 4'b0000) $display("FAIL reset_hold: flags=%b exp=0000", flags); else passed++;
  endtask

  task automatic test_zero_detect();
    set_flags(64'h0, 1'b0, 1'b0);
    total++; if (flags !== 4'b0100) $display("FAIL zd_zero: flags=%b exp=0100", flags); else passed++;
    set_flags(64'h1, 1'b0, 1'b0);
    total++; if (flags !== 4'b0000) $display("FAIL zd_one: flags=%b exp=0000", flags); else passed++;
    set_flags(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    total++; if (flags !== 4'b1000) $display("FAIL zd_msb: flags=%b exp=1000", flags); else passed++;
    set_flags(64'h0001_0000_0000_0000, 1'b0, 1'b0);
    total++; if (flags !== 4'b0000) $display("FAIL zd_bit48: flags=%b exp=0000", flags); else passed++;
  endtask

  task automatic test_cbz_cbnz();
    logic tv, tk;
    // CBZ on zero: taken, and the next-cycle request falls in the shadow.
    br_valid = 1'b1; br_op = 2'b01; br_reg = '0;
    step();
    br_op = 2'b00;
    total++; if (taken_valid !== 1'b1 || taken !== 1'b1 || shadow_state !== 1'b1)
      $display("FAIL cbz_zero: tv=%b tk=%b sh=%b exp=1/1/1", taken_valid, taken, shadow_state); else passed++;
    step();
    clear_inputs();
    total++; if (taken_valid !== 1'b0 || shadow_state !== 1'b0)
      $display("FAIL cbz_squash: tv=%b sh=%b exp=0/0", taken_valid, shadow_state); else passed++;
    step();
    do_branch(2'b10, 4'b0000, 64'h0000_0000_0001_0000, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b1) $display("FAIL cbnz_bit16: tv=%b tk=%b exp=1/1", tv, tk); else passed++;
    // Not-taken CBZ followed immediately by an accepted B.
    br_valid = 1'b1; br_op = 2'b01; br_reg = 64'h0000_0000_0001_0000;
    step();
    br_op = 2'b00; br_reg = '0;
    total++; if (taken_valid !== 1'b1 || taken !== 1'b0)
      $display("FAIL cbz_nonzero: tv=%b tk=%b exp=1/0", taken_valid, taken); else passed++;
    step();
    clear_inputs();
    total++; if (taken_valid !== 1'b1 || taken !== 1'b1)
      $display("FAIL b2b_accept: tv=%b tk=%b exp=1/1", taken_valid, taken); else passed++;
    step();
  endtask

  task automatic test_forwarding();
    logic tv, tk;
    set_flags(64'h1, 1'b0, 1'b0);
    flag_we = 1'b1; alu_result = '0;
    br_valid = 1'b1; br_op = 2'b11; br_cond = 4'b0000;
    step();
    clear_inputs();
    total++; if (taken_valid !== 1'b1 || taken !== 1'b1 || flags !== 4'b0100)
      $display("FAIL fwd_eq: tv=%b tk=%b flags=%b exp=1/1/0100", taken_valid, taken, flags); else passed++;
    step();
    set_flags(64'h1, 1'b0, 1'b0);
    do_branch(2'b11, 4'b0000, '0, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b0) $display("FAIL nofwd_eq: tv=%b tk=%b exp=1/0", tv, tk); else passed++;
  endtask

  task automatic test_signed();
    logic tv, tk;
    set_flags(64'h8000_0000_0000_0000, 1'b0, 1'b0);  // N=1 Z=0 C=0 V=0
    do_branch(2'b11, 4'b1011, '0, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b1) $display("FAIL cond_lt: tv=%b tk=%b exp=1/1", tv, tk); else passed++;
    do_branch(2'b11, 4'b1010, '0, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b0) $display("FAIL cond_ge: tv=%b tk=%b exp=1/0", tv, tk); else passed++;
    do_branch(2'b11, 4'b1100, '0, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b0) $display("FAIL cond_gt_n: tv=%b tk=%b exp=1/0", tv, tk); else passed++;
    do_branch(2'b11, 4'b1101, '0, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b1) $display("FAIL cond_le: tv=%b tk=%b exp=1/1", tv, tk); else passed++;
    do_branch(2'b11, 4'b0100, '0, tv, tk);
    total++; if (tk !== 1'b1) $display("FAIL cond_mi: tk=%b exp=1", tk); else passed++;
    set_flags(64'h1, 1'b1, 1'b0);                    // N=0 Z=0 C=1 V=0
    do_branch(2'b11, 4'b1100, '0, tv, tk);
    total++; if (tv !== 1'b1 || tk !== 1'b1) $display("FAIL cond_gt_p: tv=%b tk=%b exp=1/1", tv, tk); else passed++;
    do_branch(2'b11, 4'b1000, '0, tv, tk);
    total++; if (tk !== 1'b1) $display("FAIL cond_hi: tk=%b exp=1", tk); else passed++;
    do_branch(2'b11, 4'b1001, '0, tv, tk);
    total++; if (tk !== 1'b0) $display("FAIL cond_ls: tk=%b exp=0", tk); else passed++;
    do_branch(2'b11, 4'b0111, '0, tv, tk);
    total++; if (tk !== 1'b1) $display("FAIL cond_vc: tk=%b exp=1", tk); else passed++;
    do_branch(2'b11, 4'b0011, '0, tv, tk);
    total++; if (tk !== 1'b0) $display("FAIL cond_cc: tk=%b exp=0", tk); else passed++;
    do_branch(2'b11, 4'b1111, '0, tv, tk);
    total++; if (tk !== 1'b1) $display("FAIL cond_nv: tk=%b exp=1", tk); else passed++;
  endtask

  task automatic test_shadow_flush();
    br_valid = 1'b1; br_op = 2'b00;
    step();
    // Shadow cycle: request is wrong-path, flag write still lands.
    br_op = 2'b01; br_reg = '0; flag_we = 1'b1; alu_result = '0;
    total++; if (taken_valid !== 1'b1 || taken !== 1'b1)
      $display("FAIL shadow_b: tv=%b tk=%b exp=1/1", taken_valid, taken); else passed++;
    step();
    clear_inputs();
    total++; if (taken_valid !== 1'b0 || flags !== 4'b0100 || shadow_state !== 1'b0)
      $display("FAIL shadow_squash: tv=%b flags=%b sh=%b exp=0/0100/0", taken_valid, flags, shadow_state); else passed++;
    br_valid = 1'b1; br_op = 2'b00; flush = 1'b1; flag_we = 1'b1; alu_result = 64'h1;
    step();
    clear_inputs();
    total++; if (taken_valid !== 1'b0 || flags !== 4'b0100)
      $display("FAIL flush_kill: tv=%b flags=%b exp=0/0100", taken_valid, flags); else passed++;
    step();
  endtask

  task automatic test_reset_mid_op();
    br_valid = 1'b1; br_op = 2'b00;
    step();
    clear_inputs();
    total++; if (shadow_state !== 1'b1 || taken_valid !== 1'b1)
      $display("FAIL rst_pre: sh=%b tv=%b exp=1/1", shadow_state, taken_valid); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (taken_valid !== 1'b0 || taken !== 1'b0 || flags !== 4'b0000 || shadow_state !== 1'b0)
      $display("FAIL rst_mid: tv=%b tk=%b flags=%b sh=%b exp=0/0/0000/0", taken_valid, taken, flags, shadow_state); else passed++;
    #1 reset = 1'b1;
    br_valid = 1'b1; br_op = 2'b00;
    step();
    clear_inputs();
    total++; if (taken_valid !== 1'b1 || taken !== 1'b1)
      $display("FAIL rst_first_req: tv=%b tk=%b exp=1/1", taken_valid, taken); else passed++;
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_zero_detect();
    test_cbz_cbnz();
    test_forwarding();
    test_signed();
    test_shadow_flush();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
